alu_share_arbiter: RTL and testbench

Sequencing front end that shares the single 4-bit ALU (add, subtract, compare, AND) between two independent requesters. It arbitrates round-robin, drives the operation select and operands into the ALU, waits a programmable settle time, captures the selected result, and returns it on a shared response channel tagged with the requester ID. The block sits directly above the ALU; the ALU itself stays purely combinational.

---
 rtl/alu_share_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin front end sharing one combinational 4-bit ALU between
//            two requesters, with programmable settle time and tagged response.
// Revision : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [1:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic [1:0] alu_s,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_sum,
    input  logic       alu_carry,
    input  logic       alu_gt,
    input  logic       alu_eq,
    input  logic       alu_lt,
    input  logic [3:0] alu_and,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_data,
    output logic       rsp_carry,
    output logic       rsp_gt,
    output logic       rsp_eq,
    output logic       rsp_lt,
    output logic [7:0] op_count
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_issue  = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;

    localparam logic [1:0] c_op_add    = 2'b00;
    localparam logic [1:0] c_op_sub    = 2'b01;
    localparam logic [1:0] c_op_cmp    = 2'b10;

    localparam logic [3:0] c_settle_init = 4'(SETTLE_CYCLES - 1);

    logic [1:0] r_state;
    logic       r_last_grant;
    logic [3:0] r_settle_cnt;
    logic [1:0] r_op;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_id;
    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic [3:0] r_rsp_data;
    logic       r_rsp_carry;
    logic       r_rsp_gt;
    logic       r_rsp_eq;
    logic       r_rsp_lt;
    logic [7:0] r_op_count;

    logic       w_idle;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_drive;
    logic [3:0] w_res_data;
    logic       w_res_carry;
    logic       w_res_gt;
    logic       w_res_eq;
    logic       w_res_lt;

    // On a tie the requester that did not win last time is granted.
    assign w_grant0   = req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1   = req1_valid && (!req0_valid || !r_last_grant);
    assign w_idle     = (r_state == c_st_idle) && !rst;
    assign req0_ready = w_idle && w_grant0;
    assign req1_ready = w_idle && w_grant1;

    assign w_drive = (r_state == c_st_issue) || (r_state == c_st_resp);
    assign alu_s   = w_drive ? r_op : 2'b00;
    assign alu_a   = w_drive ? r_a  : 4'b0000;
    assign alu_b   = w_drive ? r_b  : 4'b0000;

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_carry = r_rsp_carry;
    assign rsp_gt    = r_rsp_gt;
    assign rsp_eq    = r_rsp_eq;
    assign rsp_lt    = r_rsp_lt;
    assign op_count  = r_op_count;

    // Only the ALU outputs relevant to the latched op reach the response.
    always_comb begin
        w_res_data  = 4'b0000;
        w_res_carry = 1'b0;
        w_res_gt    = 1'b0;
        w_res_eq    = 1'b0;
        w_res_lt    = 1'b0;
        case (r_op)
            c_op_add, c_op_sub: begin
                w_res_data  = alu_sum;
                w_res_carry = alu_carry;
            end
            c_op_cmp: begin
                w_res_gt = alu_gt;
                w_res_eq = alu_eq;
                w_res_lt = alu_lt;
            end
            default: w_res_data = alu_and;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_last_grant <= 1'b1;
            r_settle_cnt <= 4'd0;
            r_op         <= 2'b00;
            r_a          <= 4'b0000;
            r_b          <= 4'b0000;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= 4'b0000;
            r_rsp_carry  <= 1'b0;
            r_rsp_gt     <= 1'b0;
            r_rsp_eq     <= 1'b0;
            r_rsp_lt     <= 1'b0;
            r_op_count   <= 8'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_grant0 || w_grant1) begin
                        r_op         <= w_grant1 ? req1_op : req0_op;
                        r_a          <= w_grant1 ? req1_a  : req0_a;
                        r_b          <= w_grant1 ? req1_b  : req0_b;
                        r_id         <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_settle_cnt <= c_settle_init;
                        r_state      <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    if (r_settle_cnt == 4'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_data  <= w_res_data;
                        r_rsp_carry <= w_res_carry;
                        r_rsp_gt    <= w_res_gt;
                        r_rsp_eq    <= w_res_eq;
                        r_rsp_lt    <= w_res_lt;
                        r_state     <= c_st_resp;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                c_st_resp: begin
                    if (r_rsp_valid && rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_op_count  <= r_op_count + 8'd1;
                        r_state     <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Self-checking bench; instance 0 uses SETTLE_CYCLES=1, instance 1
//            uses SETTLE_CYCLES=3, both fed from shared requester stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
    logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
    logic       rsp_ready = 1'b0;

    logic       rdy0 [2];
    logic       rdy1 [2];
    logic [1:0] as_  [2];
    logic [3:0] aa   [2];
    logic [3:0] ab   [2];
    logic [3:0] asum [2];
    logic       acar [2];
    logic       agt  [2];
    logic       aeq  [2];
    logic       alt  [2];
    logic [3:0] aand [2];
    logic       rv   [2];
    logic       rid  [2];
    logic [3:0] rdata[2];
    logic       rcar [2];
    logic       rgt  [2];
    logic       reqf [2];
    logic       rlt  [2];
    logic [7:0] cnt  [2];

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;
    int acc_log[$];
    int hs_log[$];
    bit rsp_log[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational ALU as seen by the block: subtract is a + ~b + 1.
    for (genvar k = 0; k < 2; k++) begin : g_alu
        assign {acar[k], asum[k]} = {1'b0, aa[k]} + {1'b0, (as_[k][0] ? ~ab[k] : ab[k])} + {4'd0, as_[k][0]};
        assign agt[k]  = aa[k] > ab[k];
        assign aeq[k]  = aa[k] == ab[k];
        assign alt[k]  = aa[k] < ab[k];
        assign aand[k] = aa[k] & ab[k];
    end

    alu_share_arbiter #(.SETTLE_CYCLES(1)) u_dut_s1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(rdy0[0]),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(rdy1[0]),
        .alu_s(as_[0]), .alu_a(aa[0]), .alu_b(ab[0]),
        .alu_sum(asum[0]), .alu_carry(acar[0]), .alu_gt(agt[0]), .alu_eq(aeq[0]), .alu_lt(alt[0]), .alu_and(aand[0]),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_id(rid[0]), .rsp_data(rdata[0]), .rsp_carry(rcar[0]),
        .rsp_gt(rgt[0]), .rsp_eq(reqf[0]), .rsp_lt(rlt[0]), .op_count(cnt[0])
    );

    alu_share_arbiter #(.SETTLE_CYCLES(3)) u_dut_s3 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(rdy0[1]),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(rdy1[1]),
        .alu_s(as_[1]), .alu_a(aa[1]), .alu_b(ab[1]),
        .alu_sum(asum[1]), .alu_carry(acar[1]), .alu_gt(agt[1]), .alu_eq(aeq[1]), .alu_lt(alt[1]), .alu_and(aand[1]),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_id(rid[1]), .rsp_data(rdata[1]), .rsp_carry(rcar[1]),
        .rsp_gt(rgt[1]), .rsp_eq(reqf[1]), .rsp_lt(rlt[1]), .op_count(cnt[1])
    );

    function automatic int settle(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Expected {data, carry, gt, eq, lt} from plain integer arithmetic.
    function automatic logic [7:0] exp_rsp(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia, ib, s;
        logic [3:0] d;
        logic c, g, e, l;
        ia = int'(a); ib = int'(b);
        d = 4'd0; c = 1'b0; g = 1'b0; e = 1'b0; l = 1'b0;
        case (op)
            2'd0: begin s = ia + ib; d = 4'(s % 16); c = (s >= 16); end
            2'd1: begin s = ia - ib; d = 4'((s + 16) % 16); c = (ia >= ib); end
            2'd2: begin g = (ia > ib); e = (ia == ib); l = (ia < ib); end
            default: d = a & b;
        endcase
        return {d, c, g, e, l};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    // Issues one operation on the idle block and waits for its response.
    task automatic do_single(input int k, input bit id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                             output int lat, output logic [7:0] rsp, output logic rsp_id_o, output logic rdy);
        int e;
        if (id == 1'b0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
        else            begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
        #1;
        rdy = id ? rdy1[k] : rdy0[k];
        step();
        e = cyc;
        req0_valid = 1'b0; req1_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            step();
            if (rv[k]) lat = cyc - e;
        end
        rsp = {rdata[k], rcar[k], rgt[k], reqf[k], rlt[k]};
        rsp_id_o = rid[k];
        vectors++;
        if (lat < 0) begin fails++; $display("FAIL single_timeout: got no rsp_valid, expected one within 40 cycles"); end
    endtask

    // Random traffic against a transaction-level model of arbitration and timing.
    task automatic run_traffic(input int k, input int nops, input bit all);
        bit pv[2];
        logic [1:0] pop[2];
        logic [3:0] pa[2], pb[2];
        bit in_flight, last, er0, er1, erv, fl_id;
        logic [1:0] fl_op;
        logic [3:0] fl_a, fl_b;
        logic [7:0] e;
        int acc_edge, mcount, done, cycles, s;
        in_flight = 0; last = 1; fl_id = 0; fl_op = 0; fl_a = 0; fl_b = 0;
        acc_edge = 0; mcount = 0; done = 0; cycles = 0; s = settle(k);
        for (int r = 0; r < 2; r++) begin pv[r] = 0; pop[r] = 0; pa[r] = 0; pb[r] = 0; end
        acc_log.delete(); hs_log.delete(); rsp_log.delete();
        while (done < nops && cycles < nops * 20 + 100) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && (all || $urandom_range(2) != 0)) begin
                    pv[r] = 1; pop[r] = 2'($urandom_range(3));
                    pa[r] = 4'($urandom_range(15)); pb[r] = 4'($urandom_range(15));
                end
            end
            req0_valid = pv[0]; req0_op = pop[0]; req0_a = pa[0]; req0_b = pb[0];
            req1_valid = pv[1]; req1_op = pop[1]; req1_a = pa[1]; req1_b = pb[1];
            rsp_ready = all ? 1'b1 : 1'($urandom_range(1));
            #1;
            er0 = !in_flight && pv[0] && (!pv[1] || last);
            er1 = !in_flight && pv[1] && (!pv[0] || !last);
            erv = in_flight && (cyc >= acc_edge + s);
            vectors++;
            if ({rdy0[k], rdy1[k]} !== {er0, er1}) begin
                fails++; $display("FAIL traffic_ready: got %b%b, expected %b%b at cycle %0d", rdy0[k], rdy1[k], er0, er1, cyc);
            end
            vectors++;
            if (rv[k] !== erv) begin fails++; $display("FAIL traffic_rsp_valid: got %b, expected %b at cycle %0d", rv[k], erv, cyc); end
            vectors++;
            if ({as_[k], aa[k], ab[k]} !== (in_flight ? {fl_op, fl_a, fl_b} : 10'd0)) begin
                fails++; $display("FAIL traffic_alu_drive: got %h, expected %h", {as_[k], aa[k], ab[k]}, (in_flight ? {fl_op, fl_a, fl_b} : 10'd0));
            end
            if (erv && rv[k]) begin
                e = exp_rsp(fl_op, fl_a, fl_b);
                vectors++;
                if ({rid[k], rdata[k], rcar[k], rgt[k], reqf[k], rlt[k]} !== {fl_id, e}) begin
                    fails++; $display("FAIL traffic_rsp: got %h, expected %h (op %0d a %0d b %0d)",
                                      {rid[k], rdata[k], rcar[k], rgt[k], reqf[k], rlt[k]}, {fl_id, e}, fl_op, fl_a, fl_b);
                end
            end
            vectors++;
            if (cnt[k] !== 8'(mcount)) begin fails++; $display("FAIL traffic_op_count: got %0d, expected %0d", cnt[k], 8'(mcount)); end
            if (erv && rsp_ready) begin
                hs_log.push_back(cyc + 1); rsp_log.push_back(fl_id);
                in_flight = 0; mcount++; done++;
            end else if (er0 || er1) begin
                fl_id = er1; fl_op = pop[fl_id]; fl_a = pa[fl_id]; fl_b = pb[fl_id];
                in_flight = 1; acc_edge = cyc + 1; last = fl_id; pv[fl_id] = 0;
                acc_log.push_back(cyc + 1);
            end
            step();
            cycles++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        vectors++;
        if (done != nops) begin fails++; $display("FAIL traffic_timeout: got %0d responses, expected %0d", done, nops); end
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if ({rdy0[k], rdy1[k], rv[k], cnt[k], as_[k]} !== 13'd0) begin
                    fails++; $display("FAIL reset_state: got %h, expected 0 (dut %0d)", {rdy0[k], rdy1[k], rv[k], cnt[k], as_[k]}, k);
                end
            end
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({rdy0[0], rdy1[0], rdy0[1], rdy1[1]} !== 4'b1010) begin
            fails++; $display("FAIL reset_first_tie: got %b, expected 1010", {rdy0[0], rdy1[0], rdy0[1], rdy1[1]});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_add();
        int lat; logic [7:0] rsp; logic id_o, rdy;
        apply_reset();
        rsp_ready = 1'b1;
        do_single(0, 1'b0, 2'b00, 4'b0111, 4'b1011, lat, rsp, id_o, rdy);
        vectors++; if (rdy !== 1'b1) begin fails++; $display("FAIL add_ready: got %b, expected 1", rdy); end
        vectors++; if (lat !== 1) begin fails++; $display("FAIL add_latency: got %0d, expected 1", lat); end
        vectors++; if (id_o !== 1'b0) begin fails++; $display("FAIL add_id: got %b, expected 0", id_o); end
        vectors++; if (rsp !== 8'b0010_1_000) begin fails++; $display("FAIL add_rsp: got %b, expected 00101000", rsp); end
        step();
        vectors++;
        if ({rv[0], cnt[0]} !== {1'b0, 8'd1}) begin fails++; $display("FAIL add_complete: got %h, expected 001", {rv[0], cnt[0]}); end
    endtask

    task automatic test_sub_cmp();
        int lat; logic [7:0] rsp; logic id_o, rdy;
        logic [1:0] ops [3] = '{2'b01, 2'b01, 2'b10};
        logic [3:0] as_v[3] = '{4'b0101, 4'b0011, 4'b1001};
        logic [3:0] bs_v[3] = '{4'b0011, 4'b0101, 4'b1001};
        logic [7:0] exp [3] = '{8'b0010_1_000, 8'b1110_0_000, 8'b0000_0_010};
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_single(0, 1'b1, ops[i], as_v[i], bs_v[i], lat, rsp, id_o, rdy);
            vectors++;
            if ({rdy, id_o, rsp} !== {2'b11, exp[i]}) begin
                fails++; $display("FAIL sub_cmp_%0d: got %b, expected %b", i, {rdy, id_o, rsp}, {2'b11, exp[i]});
            end
            step();
        end
        vectors++;
        if (cnt[0] !== 8'd3) begin fails++; $display("FAIL sub_cmp_count: got %0d, expected 3", cnt[0]); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        run_traffic(0, 4, 1'b1);
        vectors++;
        if (rsp_log.size() != 4 || acc_log.size() != 4) begin
            fails++; $display("FAIL rr_count: got %0d responses, expected 4", rsp_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (rsp_log[i] !== 1'(i % 2)) begin fails++; $display("FAIL rr_id_%0d: got %b, expected %0d", i, rsp_log[i], i % 2); end
            end
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (acc_log[i + 1] - hs_log[i] != 1) begin
                    fails++; $display("FAIL rr_gap_%0d: got %0d, expected 1", i, acc_log[i + 1] - hs_log[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b11; req0_a = 4'b1100; req0_b = 4'b1010;
        #1;
        vectors++; if (rdy0[1] !== 1'b1) begin fails++; $display("FAIL bp_accept: got %b, expected 1", rdy0[1]); end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 4'd1; req1_b = 4'd1;
        #1;
        for (int i = 0; i < 9; i++) begin
            vectors++;
            if ({as_[1], aa[1], ab[1], rdy0[1], rdy1[1]} !== {2'b11, 4'b1100, 4'b1010, 2'b00}) begin
                fails++; $display("FAIL bp_alu_hold_%0d: got %h, expected %h", i, {as_[1], aa[1], ab[1], rdy0[1], rdy1[1]}, {2'b11, 4'b1100, 4'b1010, 2'b00});
            end
            vectors++;
            if (rv[1] !== (i >= 3)) begin fails++; $display("FAIL bp_rsp_valid_%0d: got %b, expected %b", i, rv[1], (i >= 3)); end
            if (i >= 3) begin
                vectors++;
                if ({rid[1], rdata[1], rcar[1], rgt[1], reqf[1], rlt[1]} !== 9'b0_1000_0000) begin
                    fails++; $display("FAIL bp_rsp_data_%0d: got %b, expected 010000000", i, {rid[1], rdata[1], rcar[1], rgt[1], reqf[1], rlt[1]});
                end
            end
            if (i < 8) step();
        end
        rsp_ready = 1'b1;
        req1_valid = 1'b0;
        step();
        vectors++;
        if ({rv[1], cnt[1], as_[1]} !== {1'b0, 8'd1, 2'b00}) begin
            fails++; $display("FAIL bp_complete: got %h, expected 004", {rv[1], cnt[1], as_[1]});
        end
    endtask

    task automatic test_reset_midop();
        apply_reset();
        rsp_ready = 1'b1;
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 4'd9; req1_b = 4'd2;
        #1;
        step();
        req1_valid = 1'b0;
        vectors++; if (as_[1] !== 2'b01) begin fails++; $display("FAIL midop_issue: got %b, expected 01", as_[1]); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if ({rv[1], cnt[1], as_[1], aa[1]} !== 15'd0) begin
                fails++; $display("FAIL midop_discard_%0d: got %h, expected 0", i, {rv[1], cnt[1], as_[1], aa[1]});
            end
            step();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        vectors++;
        if ({rdy0[1], rdy1[1]} !== 2'b10) begin fails++; $display("FAIL midop_tie: got %b, expected 10", {rdy0[1], rdy1[1]}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        run_traffic(0, 40, 1'b0);
        apply_reset();
        run_traffic(1, 40, 1'b0);
    endtask

    task automatic test_wrap();
        apply_reset();
        run_traffic(0, 256, 1'b1);
        vectors++;
        if (cnt[0] !== 8'd0) begin fails++; $display("FAIL wrap_count: got %0d, expected 0", cnt[0]); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_cmp();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
